// File: rtl/exu_mc.sv
// exu_mc: multi-cycle execute unit with valid/ready handshake, flush and a registered ALU.
// Define MDU_EN to build the iterative RV32M multiply/divide datapath and the MD_BUSY state.
module exu_mc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic             is_md,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm,
  input  logic             alu_sel_left,
  input  logic [1:0]       alu_sel_right,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             busy
);
  localparam int SH_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
`ifdef MDU_EN
    MD_BUSY = 2'd1,
`endif
    DONE    = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic             accept, res_we;
  logic [WIDTH-1:0] left, right, alu_res, res_nx;
  logic [SH_W-1:0]  shamt;

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready) | flush;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign left      = alu_sel_left ? pc : rs1;
  assign right     = (alu_sel_right == 2'b00) ? rs2 :
                     (alu_sel_right == 2'b10) ? WIDTH'(4) : imm;
  assign shamt     = right[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    case (alu_op)
      4'd0:    alu_res = left + right;
      4'd1:    alu_res = left - right;
      4'd2:    alu_res = left << shamt;
      4'd3:    alu_res = {{(WIDTH-1){1'b0}}, $signed(left) < $signed(right)};
      4'd4:    alu_res = {{(WIDTH-1){1'b0}}, left < right};
      4'd5:    alu_res = left ^ right;
      4'd6:    alu_res = left >> shamt;
      4'd7:    alu_res = $unsigned($signed(left) >>> shamt);
      4'd8:    alu_res = left | right;
      4'd9:    alu_res = left & right;
      4'd10:   alu_res = right;
      default: alu_res = '0;
    endcase
  end

`ifdef MDU_EN
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   md_hi, md_lo, md_b, nx_hi, nx_lo, md_res, sp_res, a_mag, b_mag;
  logic [2:0]         md_op_q;
  logic               a_neg, b_neg, a_sgn, b_sgn, md_special, last_step;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod;

  // Iteration runs on magnitudes; signs are reapplied on the final step.
  assign a_sgn      = (md_op == 3'd1) | (md_op == 3'd2) | (md_op == 3'd4) | (md_op == 3'd6);
  assign b_sgn      = (md_op == 3'd1) | (md_op == 3'd4) | (md_op == 3'd6);
  assign a_mag      = (a_sgn & left[WIDTH-1])  ? -left  : left;
  assign b_mag      = (b_sgn & right[WIDTH-1]) ? -right : right;
  assign md_special = md_op[2] & ((right == '0) | (!md_op[0] & (left == MIN_NEG) & (&right)));
  assign sp_res     = (right == '0) ? (md_op[1] ? left : '1) : (md_op[1] ? '0 : MIN_NEG);
  assign last_step  = (state == MD_BUSY) & (cnt == CNT_W'(1));
  assign busy       = (state == MD_BUSY);

  // hi/lo hold accumulator/multiplier for mul, remainder/quotient for div.
  always_comb begin
    md_res   = '0;
    mul_sum  = {1'b0, md_hi} + {1'b0, (md_lo[0] ? md_b : {WIDTH{1'b0}})};
    div_sh   = {md_hi, md_lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, md_b};
    if (md_op_q[2]) begin
      nx_hi = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
      nx_lo = {md_lo[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      nx_hi = mul_sum[WIDTH:1];
      nx_lo = {mul_sum[0], md_lo[WIDTH-1:1]};
    end
    prod = {nx_hi, nx_lo};
    if (a_neg ^ b_neg) prod = -prod;
    case (md_op_q)
      3'd0:                md_res = prod[WIDTH-1:0];
      3'd1, 3'd2, 3'd3:    md_res = prod[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:          md_res = (a_neg ^ b_neg) ? -nx_lo : nx_lo;
      default:             md_res = a_neg ? -nx_hi : nx_hi;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      md_hi   <= '0;
      md_lo   <= '0;
      md_b    <= '0;
      md_op_q <= '0;
      a_neg   <= 1'b0;
      b_neg   <= 1'b0;
    end else if (accept | flush) begin
      cnt <= '0;
      if (accept & is_md & !md_special) begin
        cnt     <= CNT_W'(WIDTH);
        md_hi   <= '0;
        md_lo   <= a_mag;
        md_b    <= b_mag;
        md_op_q <= md_op;
        a_neg   <= a_sgn & left[WIDTH-1];
        b_neg   <= b_sgn & right[WIDTH-1];
      end
    end else if (state == MD_BUSY) begin
      md_hi <= nx_hi;
      md_lo <= nx_lo;
      cnt   <= cnt - CNT_W'(1);
    end
  end
`else
  logic unused_md;
  assign unused_md = ^{is_md, md_op, 1'(CNT_W)};
  assign busy      = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      DONE:    if (out_ready) state_nx = IDLE;
`ifdef MDU_EN
      MD_BUSY: if (cnt == CNT_W'(1)) state_nx = DONE;
`endif
      default: ;
    endcase
    if (flush) state_nx = IDLE;
    if (accept) begin
`ifdef MDU_EN
      state_nx = (is_md & !md_special) ? MD_BUSY : DONE;
`else
      state_nx = DONE;
`endif
    end
  end

  always_comb begin
    res_we = 1'b0;
    res_nx = alu_res;
    if (accept) begin
      res_we = 1'b1;
`ifdef MDU_EN
      if (is_md) begin
        res_we = md_special;
        res_nx = sp_res;
      end
`endif
    end
`ifdef MDU_EN
    else if (last_step & !flush) begin
      res_we = 1'b1;
      res_nx = md_res;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      zero_flag <= 1'b0;
    end else if (res_we) begin
      result    <= res_nx;
      zero_flag <= (res_nx == '0);
    end
  end
endmodule

// File: tb/tb_exu_mc.sv
// Self-checking bench for exu_mc: randomized ALU/MD ops against a behavioural model.
// MD scenarios are compiled in only when MDU_EN is defined.
module tb_exu_mc;
  localparam int W = 32;
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, is_md = 1'b0, flush = 1'b0;
  logic [3:0]  alu_op = '0;
  logic [2:0]  md_op = '0;
  logic [31:0] rs1 = '0, rs2 = '0, pc = '0, imm = '0, result;
  logic        alu_sel_left = 1'b0, out_valid, out_ready = 1'b0, zero_flag, busy;
  logic [1:0]  alu_sel_right = '0;
  int          errors = 0, checks = 0;

  exu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
    .is_md(is_md), .md_op(md_op), .rs1(rs1), .rs2(rs2), .pc(pc), .imm(imm),
    .alu_sel_left(alu_sel_left), .alu_sel_right(alu_sel_right), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero_flag(zero_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic md, input logic [2:0] mop, input logic [3:0] aop,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                       input logic [31:0] im, input logic sl, input logic [1:0] sr);
    in_valid = v; is_md = md; md_op = mop; alu_op = aop;
    rs1 = a; rs2 = b; pc = p; imm = im; alu_sel_left = sl; alu_sel_right = sr;
  endtask

  function automatic logic [31:0] pick_r(logic [1:0] sr, logic [31:0] b, logic [31:0] im);
    if (sr == 2'b00) return b;
    if (sr == 2'b10) return 32'd4;
    return im;
  endfunction

  function automatic logic [31:0] alu_ref(logic [3:0] op, logic [31:0] l, logic [31:0] r);
    int sh;
    sh = int'(r % 32);
    case (op)
      4'd0: return l + r;
      4'd1: return l - r;
      4'd2: return l << sh;
      4'd3: return (int'(l) < int'(r)) ? 32'd1 : 32'd0;
      4'd4: return (l < r) ? 32'd1 : 32'd0;
      4'd5: return l ^ r;
      4'd6: return l >> sh;
      4'd7: return l[31] ? ~((~l) >> sh) : (l >> sh);
      4'd8: return l | r;
      4'd9: return l & r;
      4'd10: return r;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] md_ref(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    longint sa, sb;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'd0, a}; ub = {32'd0, b};
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN && b == 32'hFFFF_FFFF) return MIN;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle: in_ready=%b out_valid=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
    end
    out_ready = 1'b0;
    drive(1, 0, 0, 4'd0, 32'h1234, 32'h1, 0, 0, 0, 2'b00);
    tick(); in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'h1235) begin
      errors++; $display("FAIL reset_preload: out_valid=%b result=%h, want 1 00001235", out_valid, result);
    end
    #2 rst = 1'b1; #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'd0 || in_ready !== 1'b1 || zero_flag !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_async: out_valid=%b result=%h in_ready=%b zero=%b busy=%b, want 0 0 1 0 0",
                         out_valid, result, in_ready, zero_flag, busy);
    end
    #1 rst = 1'b0;
    tick();
  endtask

  task automatic test_alu_directed();
    out_ready = 1'b1;
    drive(1, 0, 0, 4'd0, 32'h0, 32'h0, MIN, 32'h0, 1, 2'b10);
    tick();
    checks++;
    if (out_valid !== 1'b1 || result !== 32'h8000_0004) begin
      errors++; $display("FAIL add_pc4: out_valid=%b result=%h, want 1 80000004", out_valid, result);
    end
    drive(1, 0, 0, 4'd1, 32'd5, 32'd5, 0, 0, 0, 2'b00);
    tick();
    checks++;
    if (out_valid !== 1'b1 || result !== 32'd0 || zero_flag !== 1'b1) begin
      errors++; $display("FAIL sub_zero: out_valid=%b result=%h zero=%b, want 1 0 1", out_valid, result, zero_flag);
    end
    in_valid = 1'b0; tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL drain_idle: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, p, im, exp;
    logic [3:0] op;
    logic sl;
    logic [1:0] sr;
    out_ready = 1'b1;
    for (int i = 0; i < 48; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom; p = $urandom; im = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
      if ($urandom_range(0, 7) == 0) a = MIN;
      sl = 1'($urandom_range(0, 1)); sr = 2'($urandom_range(0, 3));
      exp = alu_ref(op, sl ? p : a, pick_r(sr, b, im));
      drive(1, 0, 0, op, a, b, p, im, sl, sr);
      tick();
      checks++;
      if (out_valid !== 1'b1 || result !== exp || zero_flag !== (exp == 0)) begin
        errors++; $display("FAIL b2b_alu[%0d] op=%0d: out_valid=%b result=%h zero=%b, want 1 %h %b",
                           i, op, out_valid, result, zero_flag, exp, exp == 0);
      end
    end
    in_valid = 1'b0; tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] r[3];
    for (int i = 0; i < 3; i++) r[i] = 32'(100 * (i + 1) + 7);
    out_ready = 1'b0;
    drive(1, 0, 0, 4'd0, 32'd7, 32'd100, 0, 0, 0, 2'b00);
    tick();
    drive(1, 0, 0, 4'd0, 32'd7, 32'd200, 0, 0, 0, 2'b00);
    checks++;
    if (out_valid !== 1'b1 || result !== r[0] || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_hold0: out_valid=%b result=%h in_ready=%b, want 1 %h 0", out_valid, result, in_ready, r[0]);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || result !== r[0] || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_hold1: out_valid=%b result=%h in_ready=%b, want 1 %h 0", out_valid, result, in_ready, r[0]);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready: in_ready=%b, want 1", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || result !== r[1]) begin
      errors++; $display("FAIL bp_second: out_valid=%b result=%h, want 1 %h", out_valid, result, r[1]);
    end
    drive(1, 0, 0, 4'd0, 32'd7, 32'd300, 0, 0, 0, 2'b00);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== r[2]) begin
      errors++; $display("FAIL bp_third: out_valid=%b result=%h, want 1 %h", out_valid, result, r[2]);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_flush_alu();
    out_ready = 1'b0;
    drive(1, 0, 0, 4'd5, 32'hF0F0, 32'h0FF0, 0, 0, 0, 2'b00);
    tick();
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_done_kill: out_valid=%b, want 0", out_valid);
    end
    drive(1, 0, 0, 4'd8, 32'h00F0, 32'h0F00, 0, 0, 0, 2'b00);
    tick();
    drive(1, 0, 0, 4'd0, 32'd40, 32'd2, 0, 0, 0, 2'b00);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'd42) begin
      errors++; $display("FAIL flush_with_op: out_valid=%b result=%h, want 1 0000002a", out_valid, result);
    end
    out_ready = 1'b1; tick();
  endtask

`ifdef MDU_EN
  task automatic test_md_op(input string name, input logic [2:0] mop, input logic [31:0] a,
                            input logic [31:0] b, input int exp_lat, input logic [31:0] exp);
    int lat, bcnt;
    out_ready = 1'b1;
    drive(1, 1, mop, 4'd0, a, b, 0, 0, 0, 2'b00);
    tick();
    in_valid = 1'b0;
    lat = 1; bcnt = 0;
    while (!out_valid && lat < 60) begin
      if (busy) bcnt++;
      tick(); lat++;
    end
    checks++;
    if (out_valid !== 1'b1 || lat != exp_lat || bcnt != exp_lat - 1 || result !== exp) begin
      errors++; $display("FAIL md_%s(%h,%h): valid=%b lat=%0d busy_cycles=%0d result=%h, want lat=%0d busy=%0d result=%h",
                         name, a, b, out_valid, lat, bcnt, result, exp_lat, exp_lat - 1, exp);
    end
    tick();
  endtask

  task automatic test_md_directed();
    test_md_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE);
    test_md_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
    test_md_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
    test_md_op("divu0", 3'd5, 32'd10, 32'd0, 1, 32'hFFFF_FFFF);
    test_md_op("remu0", 3'd7, 32'd10, 32'd0, 1, 32'd10);
    test_md_op("div_ovf", 3'd4, MIN, 32'hFFFF_FFFF, 1, MIN);
    test_md_op("rem_ovf", 3'd6, MIN, 32'hFFFF_FFFF, 1, 32'd0);
  endtask

  task automatic test_md_random();
    logic [2:0] mop;
    logic [31:0] a, b;
    int lat;
    for (int i = 0; i < 20; i++) begin
      mop = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 5) == 0) ? MIN : $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 50));
        3: b = -32'($urandom_range(1, 50));
        default: b = $urandom;
      endcase
      lat = (mop >= 4 && (b == 0 || ((mop == 4 || mop == 6) && a == MIN && b == 32'hFFFF_FFFF))) ? 1 : 33;
      test_md_op("rand", mop, a, b, lat, md_ref(mop, a, b));
    end
  endtask

  task automatic test_md_flush();
    int seen;
    out_ready = 1'b1;
    drive(1, 1, 3'd4, 4'd0, 32'd100, 32'd7, 0, 0, 0, 2'b00);
    tick(); in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL md_flush: busy=%b out_valid=%b, want 0 0", busy, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL md_flush_no_result: valid cycles=%0d, want 0", seen);
    end
    drive(1, 1, 3'd4, 4'd0, 32'd100, 32'd7, 0, 0, 0, 2'b00);
    tick(); in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    drive(1, 0, 0, 4'd0, 32'd1000, 32'd234, 0, 0, 0, 2'b00);
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL md_flush_ready: in_ready=%b, want 1", in_ready);
    end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b0 || result !== 32'd1234) begin
      errors++; $display("FAIL md_flush_add: out_valid=%b busy=%b result=%h, want 1 0 000004d2", out_valid, busy, result);
    end
    tick();
  endtask
`else
  task automatic test_md_ignored();
    logic [31:0] a, b;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom;
      drive(1, 1, 3'($urandom_range(0, 7)), 4'd0, a, b, 0, 0, 0, 2'b00);
      tick();
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b0 || result !== a + b) begin
        errors++; $display("FAIL md_ignored[%0d]: out_valid=%b busy=%b result=%h, want 1 0 %h", i, out_valid, busy, result, a + b);
      end
    end
    in_valid = 1'b0; tick();
  endtask
`endif

  initial begin
    test_reset();
    test_alu_directed();
    test_back_to_back();
    test_backpressure();
    test_flush_alu();
`ifdef MDU_EN
    test_md_directed();
    test_md_random();
    test_md_flush();
`else
    test_md_ignored();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
